// File: rtl/ysyx_22040895_mem_arb_if.sv
// ysyx_22040895_mem_arb_if
// Bundles the two requester ports (IF fetch, LS load/store) and the shared
// memory port of the memory arbiter.
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus memory)
//
// Handshake rules for every request channel (IF, LS, MEM):
//   A transfer happens on a rising clock edge where valid and ready are both 1.
//   Once valid is raised, the requester holds it and its payload stable until
//   the transfer. Responses (*_rsp_valid) are single-cycle pulses with no
//   backpressure.
interface ysyx_22040895_mem_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Instruction fetch requester
   logic                  if_req_valid_i;
   logic                  if_req_ready_o;
   logic [ADDR_W-1:0]     if_addr_i;
   logic                  if_rsp_valid_o;
   logic [DATA_W-1:0]     if_rdata_o;
   logic                  if_err_o;
   // Load/store requester
   logic                  ls_req_valid_i;
   logic                  ls_req_ready_o;
   logic [ADDR_W-1:0]     ls_addr_i;
   logic                  ls_we_i;
   logic [DATA_W-1:0]     ls_wdata_i;
   logic [DATA_W/8-1:0]   ls_wmask_i;
   logic                  ls_rsp_valid_o;
   logic [DATA_W-1:0]     ls_rdata_o;
   logic                  ls_err_o;
   // Shared memory port
   logic                  mem_req_valid_o;
   logic                  mem_req_ready_i;
   logic [ADDR_W-1:0]     mem_addr_o;
   logic                  mem_we_o;
   logic [DATA_W-1:0]     mem_wdata_o;
   logic [DATA_W/8-1:0]   mem_wmask_o;
   logic                  mem_rsp_valid_i;
   logic [DATA_W-1:0]     mem_rdata_i;

   modport slave (
      input  if_req_valid_i, if_addr_i,
      output if_req_ready_o, if_rsp_valid_o, if_rdata_o, if_err_o,
      input  ls_req_valid_i, ls_addr_i, ls_we_i, ls_wdata_i, ls_wmask_i,
      output ls_req_ready_o, ls_rsp_valid_o, ls_rdata_o, ls_err_o,
      output mem_req_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wmask_o,
      input  mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
   );

   modport master (
      output if_req_valid_i, if_addr_i,
      input  if_req_ready_o, if_rsp_valid_o, if_rdata_o, if_err_o,
      output ls_req_valid_i, ls_addr_i, ls_we_i, ls_wdata_i, ls_wmask_i,
      input  ls_req_ready_o, ls_rsp_valid_o, ls_rdata_o, ls_err_o,
      input  mem_req_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wmask_o,
      output mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
   );
endinterface

// File: rtl/ysyx_22040895_mem_arb.sv
// ysyx_22040895_mem_arb
// Two-requester (IF / LS) memory arbiter with one outstanding transaction.
// Round-robin grant on ties; the request fields are latched on acceptance and
// replayed on the memory port; the response is returned to the owner as a
// one-cycle pulse.
//
// Optional feature macro: YSYX_22040895_ARB_TIMEOUT_EN
//   defined   : watchdog counter ends a stuck REQ/WAIT after TIMEOUT_CYCLES
//               cycles with rdata = 0 and an err pulse to the owner.
//   undefined : no counter, err outputs tied low, REQ/WAIT wait forever.
//
// dbg_state exposes the FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP).
module ysyx_22040895_mem_arb #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   ysyx_22040895_mem_arb_if.slave    bus,
   output logic [1:0]                dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

   state_t              state_q;
   state_t              state_d;
   logic                owner_q;
   logic                last_grant_q;

   logic                grant_ls;
   logic                accept;
   logic                complete;
   logic                timeout_hit;
   logic                if_ready;
   logic                ls_ready;

   logic [ADDR_W-1:0]   addr_q;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] mask_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_pulse;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, arbitration and request acceptance
   always_comb begin
      state_d  = state_q;
      grant_ls = 1'b0;
      accept   = 1'b0;
      complete = 1'b0;
      if_ready = 1'b0;
      ls_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            // On a tie the requester that did not win last time goes next.
            if (bus.if_req_valid_i && bus.ls_req_valid_i) begin
               grant_ls = (last_grant_q == OWN_IF);
            end else begin
               grant_ls = bus.ls_req_valid_i;
            end
            if ((bus.if_req_valid_i || bus.ls_req_valid_i) && !rst) begin
               if_ready = !grant_ls;
               ls_ready = grant_ls;
               accept   = 1'b1;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            // A request taken by memory is never abandoned in the same cycle.
            if (bus.mem_req_ready_i) begin
               state_d = S_WAIT;
            end else if (timeout_hit) begin
               state_d = S_RESP;
            end
         end
         S_WAIT: begin
            // A real response beats a simultaneous watchdog expiry.
            if (bus.mem_rsp_valid_i) begin
               complete = 1'b1;
               state_d  = S_RESP;
            end else if (timeout_hit) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Owner / round-robin history and latched request fields
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q      <= OWN_IF;
         last_grant_q <= OWN_LS;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         mask_q       <= '0;
      end else if (accept) begin
         owner_q      <= grant_ls;
         last_grant_q <= grant_ls;
         if (grant_ls) begin
            addr_q  <= bus.ls_addr_i;
            we_q    <= bus.ls_we_i;
            wdata_q <= bus.ls_wdata_i;
            // Byte mask only means something for a store.
            mask_q  <= bus.ls_we_i ? bus.ls_wmask_i : '0;
         end else begin
            // Fetches are always plain reads.
            addr_q  <= bus.if_addr_i;
            we_q    <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
         end
      end
   end

   // Response data capture; a watchdog expiry returns zero data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (complete) begin
         rdata_q <= bus.mem_rdata_i;
      end else if (timeout_hit && (state_d == S_RESP)) begin
         rdata_q <= '0;
      end
   end

`ifdef YSYX_22040895_ARB_TIMEOUT_EN
   logic [15:0] cnt_q;
   logic        err_q;

   assign timeout_hit = ((state_q == S_REQ) || (state_q == S_WAIT)) &&
                        (cnt_q >= 16'(TIMEOUT_CYCLES - 1));
   assign err_pulse   = err_q && (state_q == S_RESP);

   // Watchdog: cleared when a request is taken, counts every REQ/WAIT cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
      end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   // Error flag marks a RESP reached through expiry rather than a response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (timeout_hit && !complete && (state_d == S_RESP)) begin
         err_q <= 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign err_pulse          = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   assign bus.if_req_ready_o  = if_ready;
   assign bus.ls_req_ready_o  = ls_ready;

   assign bus.mem_req_valid_o = (state_q == S_REQ);
   assign bus.mem_addr_o      = addr_q;
   assign bus.mem_we_o        = we_q;
   assign bus.mem_wdata_o     = wdata_q;
   assign bus.mem_wmask_o     = mask_q;

   assign bus.if_rsp_valid_o  = (state_q == S_RESP) && (owner_q == OWN_IF);
   assign bus.ls_rsp_valid_o  = (state_q == S_RESP) && (owner_q == OWN_LS);
   assign bus.if_rdata_o      = rdata_q;
   assign bus.ls_rdata_o      = rdata_q;
   assign bus.if_err_o        = err_pulse && (owner_q == OWN_IF);
   assign bus.ls_err_o        = err_pulse && (owner_q == OWN_LS);

   assign dbg_state           = state_q;

endmodule

// File: tb/tb_ysyx_22040895_mem_arb.sv
// tb_ysyx_22040895_mem_arb
// Self-checking bench for the IF/LS memory arbiter: reset values, a table of
// single transactions with memory stalls, round-robin ordering, reset while
// waiting for memory, and the watchdog (or its absence) depending on
// YSYX_22040895_ARB_TIMEOUT_EN.
module tb_ysyx_22040895_mem_arb;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 4;
   localparam int SB_W    = DATA_W + 2;

   typedef struct {
      bit          is_ls;
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
      logic [3:0]  mask;
      int          rdy_wait;
      int          rsp_wait;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ysyx_22040895_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ysyx_22040895_mem_arb #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- memory model ----------------
   int          rdy_wait = 0;
   int          rsp_wait = 0;
   int          rdy_ctr = 0;
   int          rsp_ctr = 0;
   bit          pending = 0;
   int          inject_cyc = -1;
   logic [31:0] req_addr;
   bit          fields_known = 0;
   logic [31:0] exp_addr;
   logic        exp_we;
   logic [31:0] exp_wdata;
   logic [3:0]  exp_mask;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      case (a)
         32'h8000_0000: return 32'h0010_0513;
         32'h0000_0100: return 32'h1234_5678;
         default:       return ~a;
      endcase
   endfunction

   always @(negedge clk) begin : mem_model
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rdata_i     = '0;
      if (rst) begin
         pending = 0;
         rdy_ctr = 0;
      end else if (cyc == inject_cyc) begin
         bus.mem_rsp_valid_i = 1'b1;
         bus.mem_rdata_i     = 32'hBAD0_BAD0;
      end else if (bus.mem_req_valid_o) begin
         if (fields_known) begin
            check("mem_addr", bus.mem_addr_o, exp_addr);
            check("mem_we", bus.mem_we_o, exp_we);
            check("mem_wmask", bus.mem_wmask_o, exp_mask);
            if (exp_we) check("mem_wdata", bus.mem_wdata_o, exp_wdata);
         end
         if (rdy_ctr == rdy_wait) begin
            bus.mem_req_ready_i = 1'b1;
            rdy_ctr  = 0;
            rsp_ctr  = 0;
            pending  = 1;
            req_addr = bus.mem_addr_o;
         end else begin
            rdy_ctr++;
         end
      end else if (pending) begin
         if (rsp_ctr == rsp_wait) begin
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rdata_i     = mem_read(req_addr);
            pending = 0;
         end else begin
            rsp_ctr++;
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [SB_W-1:0] exp_q[$];
   int              exp_cyc_q[$];
   bit              grant_q[$];

   always @(negedge clk) begin : monitor
      logic [SB_W-1:0] e;
      int              ec;
      #1;
      if (bus.if_rsp_valid_o || bus.ls_rsp_valid_o) begin
         check("single_owner_rsp", {bus.if_rsp_valid_o, bus.ls_rsp_valid_o} == 2'b11, 1'b0);
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 1'b1, 1'b0);
         end else begin
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            if (bus.ls_rsp_valid_o)
               check("rsp_owner_err_data", {1'b1, bus.ls_err_o, bus.ls_rdata_o}, e);
            else
               check("rsp_owner_err_data", {1'b0, bus.if_err_o, bus.if_rdata_o}, e);
            check("rsp_cycle", cyc, ec);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_reqs(input int n_if, input int n_ls,
                           input logic [31:0] if_base, input logic [31:0] ls_base,
                           input bit ls_we, input logic [31:0] ls_wdata, input logic [3:0] ls_mask,
                           input bit use_ovr, input logic [31:0] ovr_data,
                           input bit exp_err, input int lat, input bit expect_rsp);
      int left_if = n_if;
      int left_ls = n_ls;
      int k_if = 0;
      int k_ls = 0;
      int guard = 0;
      logic [31:0] a;
      while ((left_if > 0 || left_ls > 0) && guard < 400) begin
         @(negedge clk);
         guard++;
         bus.if_req_valid_i = (left_if > 0);
         bus.if_addr_i      = if_base + 32'(4 * k_if);
         bus.ls_req_valid_i = (left_ls > 0);
         bus.ls_addr_i      = ls_base + 32'(4 * k_ls);
         bus.ls_we_i        = ls_we;
         bus.ls_wdata_i     = ls_wdata;
         bus.ls_wmask_i     = ls_mask;
         #1;
         if (bus.if_req_ready_o && bus.ls_req_ready_o) check("both_ready", 1'b1, 1'b0);
         if (bus.if_req_ready_o && !bus.if_req_valid_i) check("if_ready_no_valid", 1'b1, 1'b0);
         if (bus.ls_req_ready_o && !bus.ls_req_valid_i) check("ls_ready_no_valid", 1'b1, 1'b0);
         if (bus.if_req_ready_o || bus.ls_req_ready_o) begin
            if (bus.ls_req_ready_o) begin
               a = bus.ls_addr_i;
               exp_we = ls_we;
               exp_mask = ls_we ? ls_mask : 4'h0;
               exp_wdata = ls_wdata;
               left_ls--; k_ls++;
            end else begin
               a = bus.if_addr_i;
               exp_we = 1'b0;
               exp_mask = 4'h0;
               exp_wdata = '0;
               left_if--; k_if++;
            end
            exp_addr = a;
            fields_known = 1;
            grant_q.push_back(bus.ls_req_ready_o);
            if (expect_rsp) begin
               exp_q.push_back({bus.ls_req_ready_o, exp_err, use_ovr ? ovr_data : mem_read(a)});
               exp_cyc_q.push_back(cyc + lat);
            end
         end
      end
      if (guard >= 400) check("accept_timeout", 1'b1, 1'b0);
      @(negedge clk);
      bus.if_req_valid_i = 1'b0;
      bus.ls_req_valid_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int g = 0;
      while (exp_q.size() > 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (exp_q.size() > 0) begin
         check(name, exp_q.size(), 0);
         exp_q.delete();
         exp_cyc_q.delete();
      end
      @(negedge clk);
      #1;
      check({name, "_idle_mem_valid"}, bus.mem_req_valid_o, 1'b0);
   endtask

   // ---------------- test ----------------
   vec_t vecs[4];

   initial begin : test
      vecs[0] = '{0, 32'h8000_0000, 0, 32'h0,         4'h0, 0, 0, 32'h0010_0513, 3};
      vecs[1] = '{1, 32'h0000_0100, 1, 32'hDEAD_BEEF, 4'h3, 3, 0, 32'h1234_5678, 6};
      vecs[2] = '{1, 32'h0000_0200, 0, 32'h1111_1111, 4'hF, 0, 2, 32'hFFFF_FDFF, 5};
      vecs[3] = '{0, 32'h8000_0004, 0, 32'h0,         4'h0, 1, 1, 32'h7FFF_FFFB, 5};

      rst = 1'b1;
      bus.if_req_valid_i = 0; bus.if_addr_i = '0;
      bus.ls_req_valid_i = 0; bus.ls_addr_i = '0; bus.ls_we_i = 0;
      bus.ls_wdata_i = '0; bus.ls_wmask_i = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_if_ready", bus.if_req_ready_o, 1'b0);
      check("rst_ls_ready", bus.ls_req_ready_o, 1'b0);
      check("rst_rsp_valid", {bus.if_rsp_valid_o, bus.ls_rsp_valid_o}, 2'b00);
      check("rst_err", {bus.if_err_o, bus.ls_err_o}, 2'b00);
      check("rst_mem_valid", bus.mem_req_valid_o, 1'b0);
      check("rst_mem_fields", {bus.mem_addr_o, bus.mem_we_o, bus.mem_wmask_o}, '0);
      check("rst_mem_wdata", bus.mem_wdata_o, '0);
      check("rst_rdata", {bus.if_rdata_o, bus.ls_rdata_o}, '0);
      check("rst_state", dbg_state, 2'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table: single transactions with assorted memory stalls
      for (int i = 0; i < 4; i++) begin
         rdy_wait = vecs[i].rdy_wait;
         rsp_wait = vecs[i].rsp_wait;
         run_reqs(vecs[i].is_ls ? 0 : 1, vecs[i].is_ls ? 1 : 0,
                  vecs[i].addr, vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].mask,
                  1, vecs[i].exp_rdata, 0, vecs[i].exp_lat, 1);
         drain($sformatf("vec%0d_drain", i));
      end

      // Round robin: both requesters valid from a fresh reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rdy_wait = 0; rsp_wait = 0;
      grant_q.delete();
      run_reqs(2, 2, 32'h8000_1000, 32'h0000_0500, 0, 32'h0, 4'hF, 0, 32'h0, 0, 3, 1);
      drain("rr_drain");
      check("rr_count", grant_q.size(), 4);
      if (grant_q.size() == 4) begin
         check("rr_grant0", grant_q[0], 1'b0);
         check("rr_grant1", grant_q[1], 1'b1);
         check("rr_grant2", grant_q[2], 1'b0);
         check("rr_grant3", grant_q[3], 1'b1);
      end

      // Reset while in WAIT, then a stale memory response
      rsp_wait = 100000;
      run_reqs(1, 0, 32'h8000_2000, 32'h0, 0, 32'h0, 4'h0, 0, 32'h0, 0, 3, 1);
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_mem_valid", bus.mem_req_valid_o, 1'b0);
      check("midrst_rsp", {bus.if_rsp_valid_o, bus.ls_rsp_valid_o}, 2'b00);
      check("midrst_mem_addr", bus.mem_addr_o, '0);
      check("midrst_state", dbg_state, 2'd0);
      exp_q.delete();
      exp_cyc_q.delete();
      @(negedge clk);
      rst = 1'b0;
      rsp_wait = 0;
      inject_cyc = cyc + 2;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         check("stale_rsp_ignored", {bus.if_rsp_valid_o, bus.ls_rsp_valid_o}, 2'b00);
      end
      inject_cyc = -1;
      grant_q.delete();
      run_reqs(1, 1, 32'h8000_3000, 32'h0000_0600, 1, 32'hCAFE_F00D, 4'hC, 0, 32'h0, 0, 3, 1);
      drain("post_rst_drain");
      check("post_rst_count", grant_q.size(), 2);
      if (grant_q.size() == 2) begin
         check("post_rst_grant0", grant_q[0], 1'b0);
         check("post_rst_grant1", grant_q[1], 1'b1);
      end

      // Memory that never answers
      rsp_wait = 100000;
`ifdef YSYX_22040895_ARB_TIMEOUT_EN
      run_reqs(0, 1, 32'h0, 32'h0000_0400, 0, 32'h0, 4'h0, 1, 32'h0, 1, 5, 1);
      drain("timeout_drain");
`else
      run_reqs(0, 1, 32'h0, 32'h0000_0400, 0, 32'h0, 4'h0, 1, 32'h0, 0, 5, 0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         check("no_timeout_rsp", {bus.if_rsp_valid_o, bus.ls_rsp_valid_o}, 2'b00);
         check("no_timeout_err", {bus.if_err_o, bus.ls_err_o}, 2'b00);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ysyx_22040895_mem_arb.md
# ysyx_22040895_mem_arb

Two-requester memory arbiter for the ysyx_22040895 core. It shares a single valid/ready memory port between the instruction fetch path (IF) and the load/store path (LS, driven by the store/load controls from the control unit). It keeps one transaction outstanding at a time and grants round-robin when both requesters are valid. Registered responses return to the owning requester as single-cycle pulses.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT_CYCLES`, 255, watchdog limit. Used only with `YSYX_22040895_ARB_TIMEOUT_EN`.

Ports (direction, width, meaning):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `if_req_valid_i` in 1: fetch request.
- `if_req_ready_o` out 1: fetch request accepted.
- `if_addr_i` in ADDR_W: fetch address.
- `if_rsp_valid_o` out 1: fetch response pulse.
- `if_rdata_o` out DATA_W: fetch data.
- `if_err_o` out 1: fetch timed out.
- `ls_req_valid_i` in 1: load/store request.
- `ls_req_ready_o` out 1: load/store request accepted.
- `ls_addr_i` in ADDR_W: load/store address.
- `ls_we_i` in 1: 1 = store.
- `ls_wdata_i` in DATA_W: store data.
- `ls_wmask_i` in DATA_W/8: byte-write mask.
- `ls_rsp_valid_o` out 1: load/store response pulse.
- `ls_rdata_o` out DATA_W: load data.
- `ls_err_o` out 1: load/store timed out.
- `mem_req_valid_o` out 1: memory request valid.
- `mem_req_ready_i` in 1: memory request accepted.
- `mem_addr_o` out ADDR_W: latched address.
- `mem_we_o` out 1: latched write enable.
- `mem_wdata_o` out DATA_W: latched write data.
- `mem_wmask_o` out DATA_W/8: latched mask; 0 for reads.
- `mem_rsp_valid_i` in 1: memory response.
- `mem_rdata_i` in DATA_W: memory read data.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- `owner` register: 0 = IF, 1 = LS.
- `last_grant` register: resets to LS, so the first tie goes to IF.
- IDLE, arbitration (combinational):
  - Only one requester valid: it wins.
  - Both valid: the one not equal to `last_grant` wins.
  - The winner's `*_req_ready_o` = 1; the other ready = 0.
  - No requester valid: both readies = 0.
- IDLE, on acceptance (valid & ready):
  - Latch addr, we, wdata, mask into the `mem_*` output registers.
  - IF requests force `we` = 0 and `mask` = 0.
  - Set `owner` and `last_grant` to the winner; go to REQ.
- REQ: `mem_req_valid_o` = 1 with stable latched fields. On `mem_req_ready_i` → WAIT.
- WAIT: on `mem_rsp_valid_i`, capture `mem_rdata_i` → RESP.
  - Stores also complete via `mem_rsp_valid_i`.
- RESP: owner's `*_rsp_valid_o` = 1 for exactly one cycle; its `*_rdata_o` shows the captured data → IDLE.
- Responses have no backpressure; requesters must accept the pulse.
- Both `*_req_ready_o` = 0 in every state except IDLE.
- `mem_rsp_valid_i` is ignored outside WAIT.
- `mem_req_ready_i` is ignored outside REQ.
- Non-owner `*_rsp_valid_o` is always 0.

## Timing
- Reset values: state IDLE; all `*_valid_o`, `*_ready_o`, `*_err_o` = 0; all data, address and mask outputs = 0; `last_grant` = LS.
- Latency, with zero-wait memory:
  - Accept at cycle N.
  - `mem_req_valid_o` at N+1; ready at N+1.
  - `mem_rsp_valid_i` at N+2.
  - `*_rsp_valid_o` at N+3.
  - Next acceptance possible at N+4.
- Each memory wait cycle adds one cycle of latency.
- Reset mid-transaction: all outputs deassert immediately (asynchronous) and state returns to IDLE. The in-flight transaction is abandoned; a late `mem_rsp_valid_i` arriving in IDLE is ignored.
- A request arriving while busy waits with valid held. Requesters must keep addr/data stable until ready.

## Configuration
- `YSYX_22040895_ARB_TIMEOUT_EN` defined:
  - An 8–16 bit counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES` without completing, go to RESP with rdata = 0.
  - The owner's `*_err_o` pulses with `*_rsp_valid_o`; `mem_req_valid_o` drops.
  - A normal completion in the same cycle as the timeout takes priority (err = 0).
- Macro undefined: no counter is built, `*_err_o` are tied to 0, and REQ/WAIT wait indefinitely.

## Test plan
- Single IF read to 0x8000_0000, memory returns 0x0010_0513 with zero wait → `if_rsp_valid_o` one cycle at N+3, `if_rdata_o` = 0x0010_0513, `ls_rsp_valid_o` stays 0.
- LS store to addr 0x100, wdata 0xDEAD_BEEF, mask 4'b0011, memory ready stalled 3 cycles → `mem_*` fields stable throughout, `mem_we_o` = 1, `mem_wmask_o` = 4'b0011, `ls_rsp_valid_o` pulse after the response.
- IF and LS valid together for 4 back-to-back transactions after reset → grant order IF, LS, IF, LS.
- Assert `rst` while in WAIT, then raise `mem_rsp_valid_i` after release → no `*_rsp_valid_o`; next request arbitrates normally.
- With timeout enabled and `TIMEOUT_CYCLES` = 4, memory never responds → after 4 cycles the owner gets `*_rsp_valid_o` = 1, `*_err_o` = 1, rdata = 0. Without the macro → no response ever and err = 0.
